coll_pair_sched: RTL
====================

COLL_PAIR_SCHED -- requirements
Module: coll_pair_sched

Interface
REQ-001 The block SHALL have parameter N_OBJ, default 8, giving the number of objects in the table (2..16).
REQ-002 The block SHALL have parameter IDX_W, default 3, giving the object index width (clog2 of N_OBJ).
REQ-003 The block SHALL have parameter TIMEOUT, default 64, giving the detector watchdog limit in cycles.
REQ-004 The block SHALL have ports, one per line as name direction width meaning:
- clock  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- wr_en  in  1  object-table write strobe.
- wr_addr  in  IDX_W  object index written.
- wr_x, wr_y, wr_vx, wr_vy  in  32 each  position and velocity written.
- r2_in  in  32  combined radius-squared term, sampled at start.
- start  in  1  one-cycle pulse; begins a full pair sweep.
- det_x1, det_y1, det_x2, det_y2, det_vx1, det_vy1, det_vx2, det_vy2, det_r2  out  32 each  operands to the collision detector.
- det_in_rdy  out  1  operands valid, detector may run.
- det_trial  in  1  detector collision verdict.
- det_out_rdy  in  1  detector verdict valid.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep end.
- coll_cnt  out  2*IDX_W  number of colliding pairs in last sweep.
- hit_map  out  N_OBJ  bit k set if object k is in any colliding pair.
- first_valid  out  1  at least one collision found.
- first_i, first_j  out  IDX_W each  lowest-ordered colliding pair.
- tmo_err  out  1  sticky: at least one pair timed out this sweep.

Function
REQ-005 Object table SHALL be N_OBJ entries of {x,y,vx,vy}, written on clock edge when wr_en=1 and busy=0; writes while busy=1 SHALL be ignored.
REQ-006 FSM states SHALL be IDLE, ISSUE, WAIT, RECORD, DONE.
REQ-007 IDLE: start=1 SHALL latch r2_in, set i=0, j=1, clear coll_cnt/hit_map/first_valid/first_i/first_j/tmo_err, go to ISSUE; start while not IDLE SHALL be ignored.
REQ-008 ISSUE: SHALL register det_* operands from table entries i (as 1) and j (as 2) and latched r2, assert det_in_rdy, go to WAIT.
REQ-009 WAIT: det_in_rdy and det_* SHALL be held stable; det_out_rdy=1 SHALL move to RECORD with det_trial captured.
REQ-010 det_out_rdy SHALL be ignored in every state except WAIT.
REQ-011 RECORD: det_in_rdy SHALL be 0; if captured trial=1, coll_cnt+=1, hit_map[i] and hit_map[j] set, and first_i/first_j/first_valid loaded only if first_valid was 0.
REQ-012 Pair order SHALL be (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1); after RECORD, j<N_OBJ-1 increments j, else i increments and j=i+1; after pair (N-2,N-1) go to DONE, otherwise ISSUE.
REQ-013 DONE: done=1 for exactly one cycle, then IDLE; results SHALL hold until next start.
REQ-014 busy SHALL be 1 in ISSUE, WAIT, RECORD, DONE and 0 in IDLE.
REQ-015 Minimum per-pair cost SHALL be 3 cycles (ISSUE, WAIT, RECORD) plus detector latency.
REQ-016 coll_cnt SHALL not wrap; width 2*IDX_W covers N_OBJ*(N_OBJ-1)/2.

Reset
REQ-017 resetn=0 SHALL asynchronously force IDLE and all outputs to 0 (det_* 0, det_in_rdy 0, busy 0, done 0, coll_cnt 0, hit_map 0, first_* 0, tmo_err 0) and clear the table to 0.
REQ-018 Reset mid-sweep SHALL abandon the sweep with no done pulse; first start after release begins at pair (0,1).

Configuration
REQ-019 Macro COLL_PAIR_SCHED_TIMEOUT_EN SHALL compile in a watchdog counting WAIT cycles; on reaching TIMEOUT without det_out_rdy, go to RECORD treating trial as 0 and set tmo_err.
REQ-020 Without COLL_PAIR_SCHED_TIMEOUT_EN, WAIT SHALL persist indefinitely and tmo_err SHALL be tied 0.

Verification
REQ-021 Load 3 objects (N_OBJ=3) at (0,0),(100,0),(3,4), r2_in=25, model detector flags only (0,2) -> coll_cnt=1, hit_map=101b, first_i=0, first_j=2, one done pulse.
REQ-022 N_OBJ=8, detector returns trial=0 always, 9-cycle latency -> 28 det_in_rdy assertions in order of REQ-012, coll_cnt=0, first_valid=0.
REQ-023 Detector flags (1,3) then (2,5) -> first_i=1, first_j=3 retained, coll_cnt=2, hit_map=00101110b.
REQ-024 resetn low during pair (0,4) WAIT -> det_in_rdy 0 same cycle, no done; restart reproduces full 28-pair sweep.
REQ-025 With COLL_PAIR_SCHED_TIMEOUT_EN, TIMEOUT=64, detector silent on pair (0,1) -> RECORD at WAIT cycle 64, tmo_err=1, sweep completes; without macro, block stays in WAIT.
REQ-026 start and wr_en pulsed while busy=1 -> no restart, table contents unchanged.

Source files
------------

// File: rtl/coll_pair_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | coll_pair_sched : sweeps all object pairs through an external collision  |
// | detector and accumulates hit statistics. Optional watchdog: define       |
// | COLL_PAIR_SCHED_TIMEOUT_EN.                          Revision 1.0        |
// +--------------------------------------------------------------------------+
module coll_pair_sched #(
  parameter int N_OBJ   = 8,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_addr,
  input  logic [31:0]          wr_x,
  input  logic [31:0]          wr_y,
  input  logic [31:0]          wr_vx,
  input  logic [31:0]          wr_vy,
  input  logic [31:0]          r2_in,
  input  logic                 start,
  output logic [31:0]          det_x1,
  output logic [31:0]          det_y1,
  output logic [31:0]          det_x2,
  output logic [31:0]          det_y2,
  output logic [31:0]          det_vx1,
  output logic [31:0]          det_vy1,
  output logic [31:0]          det_vx2,
  output logic [31:0]          det_vy2,
  output logic [31:0]          det_r2,
  output logic                 det_in_rdy,
  input  logic                 det_trial,
  input  logic                 det_out_rdy,
  output logic                 busy,
  output logic                 done,
  output logic [2*IDX_W-1:0]   coll_cnt,
  output logic [N_OBJ-1:0]     hit_map,
  output logic                 first_valid,
  output logic [IDX_W-1:0]     first_i,
  output logic [IDX_W-1:0]     first_j,
  output logic                 tmo_err
);

  localparam int               CNT_W    = 2 * IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    RECORD = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   i_q, i_d, j_q, j_d;
  logic [31:0]        r2_q, r2_d;
  logic               trial_q, trial_d;

  logic [31:0]        tbl_x_q [N_OBJ];
  logic [31:0]        tbl_x_d [N_OBJ];
  logic [31:0]        tbl_y_q [N_OBJ];
  logic [31:0]        tbl_y_d [N_OBJ];
  logic [31:0]        tbl_vx_q[N_OBJ];
  logic [31:0]        tbl_vx_d[N_OBJ];
  logic [31:0]        tbl_vy_q[N_OBJ];
  logic [31:0]        tbl_vy_d[N_OBJ];

  logic [31:0]        det_x1_q, det_x1_d, det_y1_q, det_y1_d;
  logic [31:0]        det_x2_q, det_x2_d, det_y2_q, det_y2_d;
  logic [31:0]        det_vx1_q, det_vx1_d, det_vy1_q, det_vy1_d;
  logic [31:0]        det_vx2_q, det_vx2_d, det_vy2_q, det_vy2_d;
  logic [31:0]        det_r2_q, det_r2_d;
  logic               det_in_rdy_q, det_in_rdy_d;

  logic [CNT_W-1:0]   coll_cnt_q, coll_cnt_d;
  logic [N_OBJ-1:0]   hit_map_q, hit_map_d;
  logic               first_valid_q, first_valid_d;
  logic [IDX_W-1:0]   first_i_q, first_i_d, first_j_q, first_j_d;

`ifdef COLL_PAIR_SCHED_TIMEOUT_EN
  localparam int      TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               tmo_err_q, tmo_err_d;
`endif

  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    r2_d          = r2_q;
    trial_d       = trial_q;
    tbl_x_d       = tbl_x_q;
    tbl_y_d       = tbl_y_q;
    tbl_vx_d      = tbl_vx_q;
    tbl_vy_d      = tbl_vy_q;
    det_x1_d      = det_x1_q;
    det_y1_d      = det_y1_q;
    det_x2_d      = det_x2_q;
    det_y2_d      = det_y2_q;
    det_vx1_d     = det_vx1_q;
    det_vy1_d     = det_vy1_q;
    det_vx2_d     = det_vx2_q;
    det_vy2_d     = det_vy2_q;
    det_r2_d      = det_r2_q;
    det_in_rdy_d  = det_in_rdy_q;
    coll_cnt_d    = coll_cnt_q;
    hit_map_d     = hit_map_q;
    first_valid_d = first_valid_q;
    first_i_d     = first_i_q;
    first_j_d     = first_j_q;
`ifdef COLL_PAIR_SCHED_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    tmo_err_d     = tmo_err_q;
`endif

    // Table is writable only between sweeps; out-of-range indices are dropped.
    if (wr_en && (state_q == IDLE) && (int'(wr_addr) < N_OBJ)) begin
      tbl_x_d[wr_addr]  = wr_x;
      tbl_y_d[wr_addr]  = wr_y;
      tbl_vx_d[wr_addr] = wr_vx;
      tbl_vy_d[wr_addr] = wr_vy;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          r2_d          = r2_in;
          i_d           = '0;
          j_d           = IDX_W'(1);
          coll_cnt_d    = '0;
          hit_map_d     = '0;
          first_valid_d = 1'b0;
          first_i_d     = '0;
          first_j_d     = '0;
`ifdef COLL_PAIR_SCHED_TIMEOUT_EN
          tmo_err_d     = 1'b0;
`endif
          state_d       = ISSUE;
        end
      end

      ISSUE: begin
        det_x1_d     = tbl_x_q[i_q];
        det_y1_d     = tbl_y_q[i_q];
        det_vx1_d    = tbl_vx_q[i_q];
        det_vy1_d    = tbl_vy_q[i_q];
        det_x2_d     = tbl_x_q[j_q];
        det_y2_d     = tbl_y_q[j_q];
        det_vx2_d    = tbl_vx_q[j_q];
        det_vy2_d    = tbl_vy_q[j_q];
        det_r2_d     = r2_q;
        det_in_rdy_d = 1'b1;
`ifdef COLL_PAIR_SCHED_TIMEOUT_EN
        wait_cnt_d   = '0;
`endif
        state_d      = WAIT;
      end

      WAIT: begin
        if (det_out_rdy) begin
          trial_d      = det_trial;
          det_in_rdy_d = 1'b0;
          state_d      = RECORD;
        end
`ifdef COLL_PAIR_SCHED_TIMEOUT_EN
        else if (wait_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          // A silent detector counts as "no collision" for this pair.
          trial_d      = 1'b0;
          tmo_err_d    = 1'b1;
          det_in_rdy_d = 1'b0;
          state_d      = RECORD;
        end else begin
          wait_cnt_d   = wait_cnt_q + TMO_W'(1);
        end
`endif
      end

      RECORD: begin
        if (trial_q) begin
          if (coll_cnt_q != {CNT_W{1'b1}}) begin
            coll_cnt_d = coll_cnt_q + CNT_W'(1);
          end
          hit_map_d[i_q] = 1'b1;
          hit_map_d[j_q] = 1'b1;
          if (!first_valid_q) begin
            first_valid_d = 1'b1;
            first_i_d     = i_q;
            first_j_d     = j_q;
          end
        end
        if (j_q != LAST_IDX) begin
          j_d     = j_q + IDX_W'(1);
          state_d = ISSUE;
        end else if (i_q == LAST_IDX - IDX_W'(1)) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + IDX_W'(1);
          j_d     = i_q + IDX_W'(2);
          state_d = ISSUE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      i_q           <= '0;
      j_q           <= '0;
      r2_q          <= '0;
      trial_q       <= 1'b0;
      for (int k = 0; k < N_OBJ; k++) begin
        tbl_x_q[k]  <= '0;
        tbl_y_q[k]  <= '0;
        tbl_vx_q[k] <= '0;
        tbl_vy_q[k] <= '0;
      end
      det_x1_q      <= '0;
      det_y1_q      <= '0;
      det_x2_q      <= '0;
      det_y2_q      <= '0;
      det_vx1_q     <= '0;
      det_vy1_q     <= '0;
      det_vx2_q     <= '0;
      det_vy2_q     <= '0;
      det_r2_q      <= '0;
      det_in_rdy_q  <= 1'b0;
      coll_cnt_q    <= '0;
      hit_map_q     <= '0;
      first_valid_q <= 1'b0;
      first_i_q     <= '0;
      first_j_q     <= '0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      j_q           <= j_d;
      r2_q          <= r2_d;
      trial_q       <= trial_d;
      tbl_x_q       <= tbl_x_d;
      tbl_y_q       <= tbl_y_d;
      tbl_vx_q      <= tbl_vx_d;
      tbl_vy_q      <= tbl_vy_d;
      det_x1_q      <= det_x1_d;
      det_y1_q      <= det_y1_d;
      det_x2_q      <= det_x2_d;
      det_y2_q      <= det_y2_d;
      det_vx1_q     <= det_vx1_d;
      det_vy1_q     <= det_vy1_d;
      det_vx2_q     <= det_vx2_d;
      det_vy2_q     <= det_vy2_d;
      det_r2_q      <= det_r2_d;
      det_in_rdy_q  <= det_in_rdy_d;
      coll_cnt_q    <= coll_cnt_d;
      hit_map_q     <= hit_map_d;
      first_valid_q <= first_valid_d;
      first_i_q     <= first_i_d;
      first_j_q     <= first_j_d;
    end
  end

`ifdef COLL_PAIR_SCHED_TIMEOUT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wait_cnt_q <= '0;
      tmo_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      tmo_err_q  <= tmo_err_d;
    end
  end
  assign tmo_err = tmo_err_q;
`else
  assign tmo_err = 1'b0;
`endif

  assign det_x1      = det_x1_q;
  assign det_y1      = det_y1_q;
  assign det_x2      = det_x2_q;
  assign det_y2      = det_y2_q;
  assign det_vx1     = det_vx1_q;
  assign det_vy1     = det_vy1_q;
  assign det_vx2     = det_vx2_q;
  assign det_vy2     = det_vy2_q;
  assign det_r2      = det_r2_q;
  assign det_in_rdy  = det_in_rdy_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign coll_cnt    = coll_cnt_q;
  assign hit_map     = hit_map_q;
  assign first_valid = first_valid_q;
  assign first_i     = first_i_q;
  assign first_j     = first_j_q;

endmodule

`default_nettype wire
